// File: rtl/fetch_pc_gen_pkg.sv
// fetch_pc_gen_pkg: shared defaults and next-pc select encoding for the fetch pc generator
package fetch_pc_gen_pkg;
  localparam int ADDR_WIDTH_DEF = 16;
  localparam int PC_STEP_DEF = 2;
  localparam int RAS_DEPTH_DEF = 4;
  localparam logic [ADDR_WIDTH_DEF-1:0] RESET_VECTOR_DEF = '0;
  typedef enum logic [2:0] {
    SEL_RESET,
    SEL_FLUSH,
    SEL_HOLD,
    SEL_RET,
    SEL_CALL,
    SEL_JUMP,
    SEL_PRED,
    SEL_SEQ
  } sel_e;
endpackage

// File: rtl/fetch_pc_gen_ras_stack.sv
// fetch_pc_gen_ras_stack: circular return-address stack; full pushes overwrite the oldest entry
module fetch_pc_gen_ras_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] top_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW:0] cnt_q, cnt_d;
  logic do_pop, do_push;
  assign empty_o = cnt_q == '0;
  assign full_o = cnt_q == (PW+1)'(DEPTH);
  assign top_o = mem_q[ptr_q - PW'(1)];
  assign do_pop = pop_i && !empty_o;
  assign do_push = push_i && !pop_i;
  // ptr_q is the next write slot; top lives one below it
  always_comb begin
    ptr_d = do_pop ? ptr_q - PW'(1) : do_push ? ptr_q + PW'(1) : ptr_q;
    cnt_d = do_pop ? cnt_q - 1'b1 : (do_push && !full_o) ? cnt_q + 1'b1 : cnt_q;
  end
  // pointer/count update and entry write
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      if (do_push) mem_q[ptr_q] <= data_i;
    end
  end
endmodule

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: priority next-pc mux and pc register with return-address stack for call/ret
module fetch_pc_gen
  import fetch_pc_gen_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int PC_STEP = PC_STEP_DEF,
  parameter int RAS_DEPTH = RAS_DEPTH_DEF,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(RESET_VECTOR_DEF)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic [ADDR_WIDTH-1:0] flush_addr_i,
  input  logic                  jump_i,
  input  logic                  call_i,
  input  logic                  ret_i,
  input  logic [ADDR_WIDTH-1:0] target_addr_i,
  input  logic                  is_branch_i,
  input  logic                  pred_taken_i,
  input  logic [ADDR_WIDTH-1:0] pred_addr_i,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic                  branch_taken_o,
  output logic                  ras_empty_o,
  output logic                  ras_full_o,
  output logic                  ret_miss_o
);
  sel_e sel;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, pc_seq, ras_top;
  logic bt_q, bt_d, miss_q, miss_d;
  assign pc_seq = pc_q + ADDR_WIDTH'(PC_STEP);
  // fixed priority: reset > flush > stall > ret > call > jump > predicted branch > sequential
  always_comb begin
    sel = reset ? SEL_RESET : flush_i ? SEL_FLUSH : stall_i ? SEL_HOLD : ret_i ? SEL_RET :
          call_i ? SEL_CALL : jump_i ? SEL_JUMP : (is_branch_i && pred_taken_i) ? SEL_PRED : SEL_SEQ;
  end
  // next-state values for pc and status flags
  always_comb begin
    pc_d = sel == SEL_RESET ? RESET_VECTOR :
           sel == SEL_FLUSH ? flush_addr_i :
           sel == SEL_HOLD ? pc_q :
           sel == SEL_RET ? (ras_empty_o ? pc_seq : ras_top) :
           sel inside {SEL_CALL, SEL_JUMP} ? target_addr_i :
           sel == SEL_PRED ? pred_addr_i : pc_seq;
    bt_d = sel == SEL_PRED || (sel == SEL_HOLD && bt_q);
    miss_d = sel == SEL_RET && ras_empty_o;
  end
  // pc and flag registers; reset is folded into the select
  always_ff @(posedge clk) begin
    pc_q <= pc_d;
    bt_q <= bt_d;
    miss_q <= miss_d;
  end
  fetch_pc_gen_ras_stack #(.WIDTH(ADDR_WIDTH), .DEPTH(RAS_DEPTH)) u_ras (
    .clk(clk),
    .reset(reset),
    .push_i(sel == SEL_CALL),
    .pop_i(sel == SEL_RET),
    .data_i(pc_seq),
    .top_o(ras_top),
    .empty_o(ras_empty_o),
    .full_o(ras_full_o)
  );
  assign pc_o = pc_q;
  assign branch_taken_o = bt_q;
  assign ret_miss_o = miss_q;
endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb_fetch_pc_gen: table-driven and hand-sequenced checks of fetch_pc_gen through an expected-value queue
module tb_fetch_pc_gen;
  localparam logic [7:0] RS = 8'h80, ST = 8'h40, FL = 8'h20, RT = 8'h10;
  localparam logic [7:0] CA = 8'h08, JM = 8'h04, BR = 8'h02, PT = 8'h01, NO = 8'h00;
  typedef struct {
    logic [7:0] ctl;
    logic [15:0] fa, ta, pa;
    logic [19:0] ex;
  } vec_t;
  typedef struct {
    logic [19:0] ex;
    int id;
  } sb_t;
  logic clk, reset, stall, flush, jump, call, ret, is_branch, pred_taken;
  logic [15:0] flush_addr, target_addr, pred_addr, pc;
  logic branch_taken, ras_empty, ras_full, ret_miss;
  vec_t tbl[$];
  sb_t sb[$];
  sb_t cur;
  int checks = 0, failures = 0, n = 0;
  fetch_pc_gen #(.ADDR_WIDTH(16), .PC_STEP(2), .RAS_DEPTH(4), .RESET_VECTOR(16'h0000)) dut (
    .clk(clk),
    .reset(reset),
    .stall_i(stall),
    .flush_i(flush),
    .flush_addr_i(flush_addr),
    .jump_i(jump),
    .call_i(call),
    .ret_i(ret),
    .target_addr_i(target_addr),
    .is_branch_i(is_branch),
    .pred_taken_i(pred_taken),
    .pred_addr_i(pred_addr),
    .pc_o(pc),
    .branch_taken_o(branch_taken),
    .ras_empty_o(ras_empty),
    .ras_full_o(ras_full),
    .ret_miss_o(ret_miss)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  function automatic logic [19:0] ex(input logic [15:0] p, input logic bt, em, fu, mi);
    return {p, bt, em, fu, mi};
  endfunction
  task automatic step(input logic [7:0] ctl, input logic [15:0] fa, ta, pa, input logic [19:0] e);
    {reset, stall, flush, ret, call, jump, is_branch, pred_taken} = ctl;
    flush_addr = fa;
    target_addr = ta;
    pred_addr = pa;
    @(posedge clk);
    sb.push_back('{e, n});
    n++;
    #1;
  endtask
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      checks++;
      if ({pc, branch_taken, ras_empty, ras_full, ret_miss} !== cur.ex) begin
        failures++;
        $display("FAIL step%0d got pc=%h bt=%b empty=%b full=%b miss=%b want pc=%h bt=%b empty=%b full=%b miss=%b",
                 cur.id, pc, branch_taken, ras_empty, ras_full, ret_miss,
                 cur.ex[19:4], cur.ex[3], cur.ex[2], cur.ex[1], cur.ex[0]);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end
  initial begin
    {reset, stall, flush, ret, call, jump, is_branch, pred_taken} = '0;
    flush_addr = '0;
    target_addr = '0;
    pred_addr = '0;
    tbl.push_back('{RS | ST | FL, 16'h1234, 16'h0, 16'h0, ex(16'h0000, 0, 1, 0, 0)});
    tbl.push_back('{NO, 16'h0, 16'h0, 16'h0, ex(16'h0002, 0, 1, 0, 0)});
    tbl.push_back('{NO, 16'h0, 16'h0, 16'h0, ex(16'h0004, 0, 1, 0, 0)});
    tbl.push_back('{NO, 16'h0, 16'h0, 16'h0, ex(16'h0006, 0, 1, 0, 0)});
    tbl.push_back('{NO, 16'h0, 16'h0, 16'h0, ex(16'h0008, 0, 1, 0, 0)});
    tbl.push_back('{FL, 16'hFFFE, 16'h0, 16'h0, ex(16'hFFFE, 0, 1, 0, 0)});
    tbl.push_back('{NO, 16'h0, 16'h0, 16'h0, ex(16'h0000, 0, 1, 0, 0)});
    tbl.push_back('{JM, 16'h0, 16'h0010, 16'h0, ex(16'h0010, 0, 1, 0, 0)});
    tbl.push_back('{CA, 16'h0, 16'h0100, 16'h0, ex(16'h0100, 0, 0, 0, 0)});
    tbl.push_back('{RT, 16'h0, 16'h0, 16'h0, ex(16'h0012, 0, 1, 0, 0)});
    tbl.push_back('{BR | PT, 16'h0, 16'h0, 16'h0080, ex(16'h0080, 1, 1, 0, 0)});
    tbl.push_back('{NO, 16'h0, 16'h0, 16'h0, ex(16'h0082, 0, 1, 0, 0)});
    tbl.push_back('{BR, 16'h0, 16'h0, 16'h0AAA, ex(16'h0084, 0, 1, 0, 0)});
    tbl.push_back('{PT, 16'h0, 16'h0, 16'h0AAA, ex(16'h0086, 0, 1, 0, 0)});
    tbl.push_back('{BR | PT, 16'h0, 16'h0, 16'h0090, ex(16'h0090, 1, 1, 0, 0)});
    tbl.push_back('{ST, 16'h0, 16'h0, 16'h0, ex(16'h0090, 1, 1, 0, 0)});
    tbl.push_back('{FL | ST, 16'h0010, 16'h0, 16'h0, ex(16'h0010, 0, 1, 0, 0)});
    tbl.push_back('{RT | CA, 16'h0, 16'h0700, 16'h0, ex(16'h0012, 0, 1, 0, 1)});
    tbl.push_back('{JM | BR | PT, 16'h0, 16'h0030, 16'h0050, ex(16'h0030, 0, 1, 0, 0)});
    tbl.push_back('{CA | JM, 16'h0, 16'h0060, 16'h0, ex(16'h0060, 0, 0, 0, 0)});
    tbl.push_back('{RS | CA, 16'h0, 16'h0900, 16'h0, ex(16'h0000, 0, 1, 0, 0)});
    tbl.push_back('{RT, 16'h0, 16'h0, 16'h0, ex(16'h0002, 0, 1, 0, 1)});
    tbl.push_back('{ST | RT, 16'h0, 16'h0, 16'h0, ex(16'h0002, 0, 1, 0, 0)});
    for (int i = 0; i < tbl.size(); i++) step(tbl[i].ctl, tbl[i].fa, tbl[i].ta, tbl[i].pa, tbl[i].ex);
    step(RS, 16'h0, 16'h0, 16'h0, ex(16'h0000, 0, 1, 0, 0));
    step(CA, 16'h0, 16'h0100, 16'h0, ex(16'h0100, 0, 0, 0, 0));
    step(CA, 16'h0, 16'h0200, 16'h0, ex(16'h0200, 0, 0, 0, 0));
    step(CA, 16'h0, 16'h0300, 16'h0, ex(16'h0300, 0, 0, 0, 0));
    step(CA, 16'h0, 16'h0400, 16'h0, ex(16'h0400, 0, 0, 1, 0));
    step(CA, 16'h0, 16'h0500, 16'h0, ex(16'h0500, 0, 0, 1, 0));
    step(RT, 16'h0, 16'h0, 16'h0, ex(16'h0402, 0, 0, 0, 0));
    step(RT, 16'h0, 16'h0, 16'h0, ex(16'h0302, 0, 0, 0, 0));
    step(RT, 16'h0, 16'h0, 16'h0, ex(16'h0202, 0, 0, 0, 0));
    step(RT, 16'h0, 16'h0, 16'h0, ex(16'h0102, 0, 1, 0, 0));
    step(RT, 16'h0, 16'h0, 16'h0, ex(16'h0104, 0, 1, 0, 1));
    step(NO, 16'h0, 16'h0, 16'h0, ex(16'h0106, 0, 1, 0, 0));
    step(CA, 16'h0, 16'h0200, 16'h0, ex(16'h0200, 0, 0, 0, 0));
    step(ST | JM, 16'h0, 16'h0300, 16'h0, ex(16'h0200, 0, 0, 0, 0));
    step(ST | CA, 16'h0, 16'h0300, 16'h0, ex(16'h0200, 0, 0, 0, 0));
    step(ST | FL, 16'h0040, 16'h0, 16'h0, ex(16'h0040, 0, 0, 0, 0));
    step(RT, 16'h0, 16'h0, 16'h0, ex(16'h0108, 0, 1, 0, 0));
    step(BR | PT, 16'h0, 16'h0, 16'h00A0, ex(16'h00A0, 1, 1, 0, 0));
    step(RS | ST, 16'h0, 16'h0, 16'h0, ex(16'h0000, 0, 1, 0, 0));
    step(NO, 16'h0, 16'h0, 16'h0, ex(16'h0002, 0, 1, 0, 0));
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
